// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains the pop side of a fifo, one word per frame.
// Frame: start bit (0), DATA_WIDTH payload bits LSB first, optional even
// parity bit, STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT cycles.
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even parity
// bit between the payload and the stop bits.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pop_valid_i,
  input  logic [DATA_WIDTH-1:0] pop_data_i,
  output logic                  pop_grant_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_WIDTH - 1);
  // The bit counter is reused to count stop bits; STOP_BITS <= 2 always fits.
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef FIFO_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                  state_q, state_d;
  logic [BaudW-1:0]        baud_q, baud_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    tx_q, tx_d;
  logic                    baud_end;

`ifdef FIFO_UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  assign baud_end = (baud_q == BaudLast);

  // Next-state logic: bit timing, payload shifting and frame sequencing.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        // pop_grant_o is high here whenever reset is low, so valid alone
        // decides the transfer.
        if (pop_valid_i) begin
          shreg_d = pop_data_i;
          state_d = StStart;
          baud_d  = '0;
          bit_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d = ^pop_data_i;
`endif
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == DataLast) begin
            bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == StopLast) begin
            bit_d   = '0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level for the next cycle, derived from where the FSM is heading so
  // that tx_o is registered yet changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset returns the line to idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Even parity of the payload, latched when the word is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign pop_grant_o  = (state_q == StIdle) & ~reset;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != StIdle);
  assign frame_done_o = (state_q == StStop) & baud_end & (bit_q == StopLast);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a default instance (16 clk/bit, one
// stop bit) and a fast instance (4 clk/bit, two stop bits) share one fifo
// model; sel routes the fifo to one of them.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;

  logic       f_valid;
  logic [7:0] f_data;
  logic       grant_a, tx_a, busy_a, done_a;
  logic       grant_b, tx_b, busy_b, done_b;
  logic       grant_sel, tx_sel, busy_sel, done_sel;

  logic [7:0] fmem [16];
  int         wr_p = 0;
  int         rd_p = 0;
  int         cyc = 0;
  int         xfer_cnt = 0;
  int         xfer_cyc = 0;
  logic [7:0] xfer_data = '0;

  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign f_valid   = (rd_p != wr_p);
  assign f_data    = fmem[rd_p[3:0]];
  assign grant_sel = sel ? grant_b : grant_a;
  assign tx_sel    = sel ? tx_b : tx_a;
  assign busy_sel  = sel ? busy_b : busy_a;
  assign done_sel  = sel ? done_b : done_a;

  fifo_uart_tx u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .pop_valid_i  (f_valid & ~sel),
    .pop_data_i   (f_data),
    .pop_grant_o  (grant_a),
    .tx_o         (tx_a),
    .busy_o       (busy_a),
    .frame_done_o (done_a)
  );

  fifo_uart_tx #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (4),
    .STOP_BITS    (2)
  ) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .pop_valid_i  (f_valid & sel),
    .pop_data_i   (f_data),
    .pop_grant_o  (grant_b),
    .tx_o         (tx_b),
    .busy_o       (busy_b),
    .frame_done_o (done_b)
  );

  // Fifo pop side plus transfer log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (f_valid && grant_sel) begin
      rd_p      <= rd_p + 1;
      xfer_cnt  <= xfer_cnt + 1;
      xfer_cyc  <= cyc;
      xfer_data <= f_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr_p[3:0]] = d;
    wr_p = wr_p + 1;
  endtask

  // Returns #1 after the transfer edge, i.e. in cycle 0 of the new frame.
  task automatic wait_xfer(input string nm);
    int start;
    bit seen;
    start = xfer_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (xfer_cnt != start) seen = 1'b1;
    end
    chk({nm, "_xfer_seen"}, 32'(seen), 32'd1);
  endtask

  function automatic int frame_len(input int stops);
`ifdef FIFO_UART_TX_PARITY_EN
    return 10 + stops;
`else
    return 9 + stops;
`endif
  endfunction

  // Wire-order bit sequence: index 0 is the start bit.
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic par, input int stops);
    logic [15:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < 8; i++) v[i+1] = d[i];
    idx = 9;
`ifdef FIFO_UART_TX_PARITY_EN
    v[idx] = par;
    idx++;
`endif
    for (int s = 0; s < stops; s++) v[idx+s] = 1'b1;
    return v;
  endfunction

  // Samples every bit mid-period, checks the done pulse position and that
  // the block is idle on the cycle after the frame.
  task automatic run_frame(input int cpb, input int stops, input logic [7:0] d,
                           input logic par, input string nm);
    logic [15:0] exp;
    int nbits, done_n, done_at;
    exp     = mk_frame(d, par, stops);
    nbits   = frame_len(stops);
    done_n  = 0;
    done_at = -1;
    chk({nm, "_data"}, 32'(xfer_data), 32'(d));
    for (int c = 0; c < nbits * cpb; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c == 0) begin
        chk({nm, "_start_first"}, 32'(tx_sel), 32'd0);
        chk({nm, "_busy"}, 32'(busy_sel), 32'd1);
      end
      if (c % cpb == cpb / 2) chk({nm, "_bit"}, 32'(tx_sel), 32'(exp[c / cpb]));
      if (done_sel) begin
        done_n++;
        done_at = c;
      end
    end
    chk({nm, "_done_count"}, 32'(done_n), 32'd1);
    chk({nm, "_done_cycle"}, 32'(done_at), 32'(nbits * cpb - 1));
    chk({nm, "_last_busy"}, 32'(busy_sel), 32'd1);
    @(posedge clk);
    #1;
    chk({nm, "_idle_busy"}, 32'(busy_sel), 32'd0);
    chk({nm, "_idle_tx"}, 32'(tx_sel), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    string      name;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   t_prev;
    int   cnt0;

    tbl[0] = '{data: 8'hA5, par: 1'b0, name: "frame_a5"};
    tbl[1] = '{data: 8'h07, par: 1'b1, name: "frame_07"};
    tbl[2] = '{data: 8'h03, par: 1'b0, name: "frame_03"};
    tbl[3] = '{data: 8'h5A, par: 1'b0, name: "frame_5a"};

    // Reset held: line idle, no grant.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_grant", 32'(grant_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Empty fifo: stay idle, grant high, nothing popped.
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (i % 10 == 0) begin
        chk("idle_tx", 32'(tx_a), 32'd1);
        chk("idle_busy", 32'(busy_a), 32'd0);
        chk("idle_grant", 32'(grant_a), 32'd1);
      end
    end
    chk("idle_no_xfer", 32'(xfer_cnt), 32'd0);

    // Single frames on the default instance.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      push(tbl[i].data);
      wait_xfer(tbl[i].name);
      run_frame(16, 1, tbl[i].data, tbl[i].par, tbl[i].name);
    end

    // Back-to-back: three queued words, fixed transfer spacing.
    @(negedge clk);
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_xfer("b2b");
      if (k > 0) chk("b2b_spacing", 32'(xfer_cyc - t_prev), 32'(frame_len(1) * 16 + 1));
      if (k == 2) chk("b2b_fifo_empty", 32'(f_valid), 32'd0);
      t_prev = xfer_cyc;
      case (k)
        0:       run_frame(16, 1, 8'h00, 1'b0, "b2b_00");
        1:       run_frame(16, 1, 8'hFF, 1'b0, "b2b_ff");
        default: run_frame(16, 1, 8'h3C, 1'b0, "b2b_3c");
      endcase
    end

    // Fast instance: 4 clk/bit, two stop bits.
    @(negedge clk);
    sel = 1'b1;
    push(8'h81);
    wait_xfer("stop2");
    run_frame(4, 2, 8'h81, 1'b0, "stop2_81");
    @(negedge clk);
    sel = 1'b0;

    // Reset at cycle 40 of a frame; the next queued word goes out cleanly.
    push(8'h5A);
    push(8'hC3);
    wait_xfer("midrst");
    cnt0 = xfer_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx_a), 32'd1);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_grant", 32'(grant_a), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_tx", 32'(tx_a), 32'd1);
    chk("midrst_no_pop", 32'(xfer_cnt), 32'(cnt0));
    @(negedge clk);
    reset = 1'b0;
    wait_xfer("after_rst");
    run_frame(16, 1, 8'hC3, 1'b0, "after_rst_c3");
    chk("after_rst_fifo_empty", 32'(f_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
